// File: rtl/jtgng_mem_pkg.sv
// Shared definitions for the jtgng memory blocks: clear FSM states,
// read-during-write policy codes and byte-lane helper.
package jtgng_mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int lane_cnt(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/jtgng_dpram_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or a clr request
// from IDLE, producing one write strobe per clock while busy.
module jtgng_dpram_clr_seq
  import jtgng_mem_pkg::*;
#(
  parameter int aw = 10
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          clr,
  output logic [aw-1:0] sweep_addr,
  output logic          sweep_we,
  output logic          busy
);

  clr_state_e     state_q, state_d;
  logic [aw:0]    cnt_q, cnt_d;
  logic [aw:0]    cnt_inc;

  // The extra MSB flags the wrap past the last word, so aw=1 needs no special case
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (state_q == ST_IDLE) begin
      if (clr) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_inc;
      if (cnt_inc[aw]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sweep_addr = cnt_q[aw-1:0];
  assign sweep_we   = (state_q == ST_CLEAR);
  assign busy       = (state_q == ST_CLEAR);

endmodule

// File: rtl/jtgng_dpram_clr.sv
// Single-clock true dual-port RAM with byte enables, port A priority on lane
// collisions and a power-up/clr clear sweep (built only with JTGNG_DPRAM_CLR_EN).
module jtgng_dpram_clr
  import jtgng_mem_pkg::*;
#(
  parameter int            dw     = 16,
  parameter int            aw     = 10,
  parameter int            RDW    = 0,
  parameter logic [dw-1:0] CLRVAL = {dw{1'b0}}
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cen_a,
  input  logic [aw-1:0]   addr_a,
  input  logic [dw-1:0]   data_a,
  input  logic [dw/8-1:0] we_a,
  output logic [dw-1:0]   q_a,
  input  logic            cen_b,
  input  logic [aw-1:0]   addr_b,
  input  logic [dw-1:0]   data_b,
  input  logic [dw/8-1:0] we_b,
  output logic [dw-1:0]   q_b,
  input  logic            clr,
  output logic            busy
);

  localparam int LN = lane_cnt(dw);

  logic [dw-1:0]   mem [0:2**aw-1];

  logic [aw-1:0]   sweep_addr;
  logic            sweep_we;
  logic            busy_i;

  logic [aw-1:0]   wa_addr;
  logic [dw-1:0]   wa_dat;
  logic [LN-1:0]   wa_en;
  logic [LN-1:0]   wb_en;

  logic [dw-1:0]   rd_a, rd_b;
  logic [dw-1:0]   q_a_q, q_a_d;
  logic [dw-1:0]   q_b_q, q_b_d;

`ifdef JTGNG_DPRAM_CLR_EN
  jtgng_dpram_clr_seq #(
    .aw (aw)
  ) u_seq (
    .rst        (rst),
    .clk        (clk),
    .clr        (clr),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we),
    .busy       (busy_i)
  );
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign sweep_addr = '0;
  assign sweep_we   = 1'b0;
  assign busy_i     = 1'b0;
`endif

  assign busy = busy_i;

  // The sweep owns port A's write path; port B writes are dropped meanwhile
  always_comb begin
    wa_addr = addr_a;
    wa_dat  = data_a;
    wa_en   = cen_a ? we_a : '0;
    wb_en   = (cen_b && !busy_i) ? we_b : '0;
    if (sweep_we) begin
      wa_addr = sweep_addr;
      wa_dat  = CLRVAL;
      wa_en   = '1;
    end
  end

  assign rd_a = mem[addr_a];
  assign rd_b = mem[addr_b];

  // Port A is written last so it takes any lane both ports enable
  always_ff @(posedge clk) begin
    for (int n = 0; n < LN; n++) begin
      if (wb_en[n]) mem[addr_b][8*n +: 8] <= data_b[8*n +: 8];
      if (wa_en[n]) mem[wa_addr][8*n +: 8] <= wa_dat[8*n +: 8];
    end
  end

  always_comb begin
    q_a_d = q_a_q;
    q_b_d = q_b_q;
    if (busy_i) begin
      q_a_d = '0;
      q_b_d = '0;
    end else begin
      if (cen_a) begin
        for (int n = 0; n < LN; n++) begin
          q_a_d[8*n +: 8] = (RDW == RDW_NEW && we_a[n]) ? data_a[8*n +: 8] : rd_a[8*n +: 8];
        end
      end
      if (cen_b) begin
        for (int n = 0; n < LN; n++) begin
          q_b_d[8*n +: 8] = (RDW == RDW_NEW && we_b[n]) ? data_b[8*n +: 8] : rd_b[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: tb/tb_jtgng_dpram_clr.sv
// Directed bench for jtgng_dpram_clr (dw=16, aw=4), one instance per read-during-write policy.
module tb_jtgng_dpram_clr;

  localparam logic [15:0] CV = 16'hE700;
`ifdef JTGNG_DPRAM_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        rst, clk, clr;
  logic        cen_a, cen_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic [1:0]  we_a, we_b;
  wire  [15:0] q_a, q_b, q_a_n, q_b_n;
  wire         busy, busy_n;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] n;
  logic [15:0] done;

  jtgng_dpram_clr #(.dw(16), .aw(4), .RDW(0), .CLRVAL(CV)) u_dut (
    .rst(rst), .clk(clk),
    .cen_a(cen_a), .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a),
    .cen_b(cen_b), .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b),
    .clr(clr), .busy(busy)
  );

  jtgng_dpram_clr #(.dw(16), .aw(4), .RDW(1), .CLRVAL(CV)) u_dut_new (
    .rst(rst), .clk(clk),
    .cen_a(cen_a), .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a_n),
    .cen_b(cen_b), .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b_n),
    .clr(clr), .busy(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    cen_a = 1'b0; cen_b = 1'b0; we_a = 2'b00; we_b = 2'b00; clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    addr_a = 4'd0; addr_b = 4'd0; data_a = 16'h0; data_b = 16'h0;
    #3;
    tick(); tick();
    chk("rst_q_a", q_a, 16'h0000);
    chk("rst_q_b", q_b, 16'h0000);
    chk("rst_q_a_new", q_a_n, 16'h0000);
    chk("rst_busy", {15'b0, busy}, {15'b0, CLR_EN});
    chk("rst_busy_new", {15'b0, busy_n}, {15'b0, CLR_EN});

    rst = 1'b0;
    n = 16'd0;
    while (busy && n < 16'd40) begin
      tick();
      n++;
    end
    chk("sweep_len", n, CLR_EN ? 16'd16 : 16'd0);

`ifdef JTGNG_DPRAM_CLR_EN
    for (int i = 0; i < 16; i++) begin
      cen_a = 1'b1; cen_b = 1'b1;
      addr_a = 4'(i); addr_b = 4'(15 - i);
      tick();
      chk("sweep_rd_a", q_a, CV);
      chk("sweep_rd_b", q_b, CV);
    end
    idle();
`endif

    // known contents for the directed cases, in either build
    cen_a = 1'b1; we_a = 2'b11; data_a = CV;
    addr_a = 4'd3; tick();
    addr_a = 4'd5; tick();
    addr_a = 4'd7; tick();
    idle();

    // low-lane write on A with same-cycle cross-port read on B
    cen_a = 1'b1; addr_a = 4'd3; data_a = 16'hABCD; we_a = 2'b01;
    cen_b = 1'b1; addr_b = 4'd3; we_b = 2'b00;
    tick();
    chk("xport_old_b", q_b, CV);
    chk("xport_old_b_new", q_b_n, CV);
    chk("rdw0_partial", q_a, CV);
    chk("rdw1_partial", q_a_n, 16'hE7CD);
    cen_a = 1'b0; we_a = 2'b00;
    tick();
    chk("partial_rd_b", q_b, 16'hE7CD);

    // same-address collision, A enables both lanes
    cen_a = 1'b1; addr_a = 4'd5; data_a = 16'h1111; we_a = 2'b11;
    cen_b = 1'b1; addr_b = 4'd5; data_b = 16'h2222; we_b = 2'b10;
    tick();
    chk("collide_old_b", q_b, CV);
    cen_a = 1'b0; we_a = 2'b00; we_b = 2'b00;
    tick();
    chk("collide_a11", q_b, 16'h1111);

    // same-address collision, A enables only the low lane
    cen_a = 1'b1; we_a = 2'b01; data_a = 16'h1111;
    we_b = 2'b10; data_b = 16'h2222;
    tick();
    cen_a = 1'b0; we_a = 2'b00; we_b = 2'b00;
    tick();
    chk("collide_a01", q_b, 16'h2211);
    idle();

    // full write while reading the same address
    cen_a = 1'b1; addr_a = 4'd7; data_a = 16'h5A5A; we_a = 2'b11;
    tick();
    chk("rdw0_full", q_a, CV);
    chk("rdw1_full", q_a_n, 16'h5A5A);

    // disabled port: no write, q holds
    cen_a = 1'b0; we_a = 2'b11; data_a = 16'hFFFF;
    tick();
    chk("cen_hold_a", q_a, CV);
    chk("cen_hold_a_new", q_a_n, 16'h5A5A);
    cen_a = 1'b1; we_a = 2'b00;
    tick();
    chk("cen_no_write", q_a, 16'h5A5A);
    idle();

`ifdef JTGNG_DPRAM_CLR_EN
    // clr sweep, second clr mid-sweep, port writes to already-swept words
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy_rise", {15'b0, busy}, 16'd1);
    done = 16'd0;
    for (int k = 1; k <= 24; k++) begin
      idle();
      if (k == 5) clr = 1'b1;
      if (k == 12) begin
        cen_a = 1'b1; addr_a = 4'd1; data_a = 16'h1234; we_a = 2'b11;
        cen_b = 1'b1; addr_b = 4'd2; data_b = 16'h4321; we_b = 2'b11;
      end
      tick();
      if (k == 12) begin
        chk("busy_q_a", q_a, 16'h0000);
        chk("busy_q_b", q_b, 16'h0000);
      end
      if (!busy && done == 16'd0) done = 16'(k);
    end
    chk("clr_sweep_len", done, 16'd16);
    idle();
    cen_a = 1'b1; addr_a = 4'd1; cen_b = 1'b1; addr_b = 4'd2;
    tick();
    chk("busy_wr_drop_a", q_a, CV);
    chk("busy_wr_drop_b", q_b, CV);
    idle();

    // reset during a sweep restarts it from address 0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick(); tick();
    chk("rst_mid_busy", {15'b0, busy}, 16'd1);
    chk("rst_mid_q_a", q_a, 16'h0000);
    rst = 1'b0;
    n = 16'd0;
    while (busy && n < 16'd40) begin
      tick();
      n++;
    end
    chk("rst_restart_len", n, 16'd16);
`else
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ignored", {15'b0, busy}, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/jtgng_dpram_clr.md
# jtgng_dpram_clr

Single-clock, true dual-port RAM with per-byte write enables, a selectable read-during-write policy, deterministic same-address write arbitration and a hardware clear sequencer. It replaces ad-hoc dual-port memories used by video and CPU-shared buffers (palette, object and shared work RAM) where both ports run on the system clock and the contents must be known after reset.

## Interface
- dw, 16, data width in bits; must be a multiple of 8
- aw, 10, address width; depth is 2**aw words
- RDW, 0, same-port read-during-write: 0 returns old data, 1 returns the newly written data
- CLRVAL, {dw{1'b0}}, word written by the clear sequencer

Ports:
- rst  input  1  asynchronous reset, active high
- clk  input  1  single clock for both ports
- cen_a  input  1  port A clock enable
- addr_a  input  aw  port A address
- data_a  input  dw  port A write data
- we_a  input  dw/8  port A byte write enables; bit n covers data_a[8n+7:8n]
- q_a  output  dw  port A registered read data
- cen_b, addr_b, data_b, we_b, q_b: same as port A, for port B
- clr  input  1  request a new clear sweep
- busy  output  1  high while a clear sweep is in progress

## Operation
- Port access happens only on cycles where that port's cen is high. With cen low, q holds and no write takes place.
- Reads:
  - Both ports are always read on an enabled cycle.
  - The result appears on q one cycle later.
  - With RDW=1, the written bytes replace the old bytes in q for a same-port write. Unwritten byte lanes always show old data.
- Cross-port read of an address the other port writes in the same cycle returns the old data.
- Same-address simultaneous writes: resolved per byte lane. Port A wins any lane that both ports enable. Lanes enabled by only one port take that port's data.
- Clear FSM, states IDLE and CLEAR:
  - Reset forces CLEAR with the sweep address at 0.
  - A clr pulse while in IDLE also enters CLEAR with the address at 0.
  - In CLEAR, one word is written with CLRVAL per clk, ignoring cen. The address increments each cycle.
  - After the write to address 2**aw-1, the FSM returns to IDLE. The address wraps to 0 and is not reused.
  - clr asserted during CLEAR is ignored; it does not restart the sweep.
- While busy:
  - Port writes are discarded.
  - q_a and q_b are forced to 0.
  - Port reads do not update q.
- The sweep address counter is aw+1 bits. The MSB marks completion, so aw=1 (depth 2) works.

## Timing
- Reset values: q_a=0, q_b=0. busy=1 when the clear feature is compiled in, otherwise 0.
- Reset asserted mid-sweep restarts the sweep from address 0 after release.
- First sweep write occurs on the first rising clk edge after rst falls.
- A full sweep takes 2**aw cycles:
  - busy rises the cycle after clr is sampled in IDLE.
  - busy falls on the edge after address 2**aw-1 is written.
- The first port access is honoured on the cycle busy is sampled low.
- Read latency is 1 enabled cycle on each port. No pipelining beyond the output register.

## Configuration
- JTGNG_DPRAM_CLR_EN defined: the clear FSM, clr and busy behave as described above.
- Macro undefined:
  - No sweep logic is built, and clr is ignored.
  - busy is tied to 0.
  - Memory contents after power-up are undefined; reset clears only q_a and q_b.
  - The block then maps onto a plain inferred true dual-port RAM with byte enables.

## Structure
- Shared package jtgng_mem_pkg holds:
  - the clear FSM state enum (ST_IDLE, ST_CLEAR)
  - RDW_OLD=0 and RDW_NEW=1
  - a lane-count function dw/8
- One sub-module, jtgng_dpram_clr_seq: the clear FSM and sweep counter. It outputs the sweep address, the sweep write strobe and busy.
  - The top level muxes the sweep onto port A's write path.
  - Port B is blocked while busy.

## Test plan
- Reset release with CLR_EN, aw=4:
  - busy stays high for exactly 16 cycles.
  - Reading all 16 addresses afterwards returns CLRVAL.
- dw=16, port A writes 0xABCD to address 3 with we_a=2'b01, then port B reads address 3:
  - q_b = {CLRVAL[15:8], 8'hCD} one cycle after the read.
- Both ports write address 5 in the same cycle:
  - A writes 0x1111 with we_a=2'b11; B writes 0x2222 with we_b=2'b10.
  - A later read gives 0x1111.
  - Repeat with we_a=2'b01: the read gives 0x2211.
- RDW=1, port A writes 0x5A5A to address 7 while reading address 7: q_a=0x5A5A next cycle. With RDW=0, q_a shows the previous contents.
- clr pulse, then clr pulsed again mid-sweep, then rst asserted mid-sweep:
  - The second clr does not extend busy.
  - rst restarts the count so busy lasts 16 cycles from rst release.
  - Port writes attempted while busy are absent afterwards.
- cen_a held low with we_a=2'b11: memory and q_a are unchanged.
